// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int WIDTH_INSTR_DEF = 8;
    localparam int WIDTH_ADDR_DEF  = 8;
    localparam int BUF_DEPTH       = 2;
    localparam logic [WIDTH_INSTR_DEF-1:0] HALT_OPCODE_DEF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [WIDTH_ADDR_DEF-1:0]  addr;
        logic [WIDTH_INSTR_DEF-1:0] instr;
    } buf_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO with synchronous flush; push and pop may coincide at any occupancy.
module fetch_buf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: storage is reset because the head word drives outputs that must read zero after reset.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

    overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !flush_i && (count_q == 2'd2) && !do_pop));

endmodule

// File: rtl/fetch_sequencer.sv
// PC controller: issues reads to a 1-cycle-latency instruction RAM and hands
// instructions to the decoder through a 2-entry buffer with credit-based issue.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int WIDTH_INSTR = WIDTH_INSTR_DEF,
    parameter int WIDTH_ADDR  = WIDTH_ADDR_DEF,
    parameter logic [WIDTH_INSTR-1:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH_ADDR-1:0]  start_addr,
    input  logic                   stop,
    input  logic                   redirect,
    input  logic [WIDTH_ADDR-1:0]  redirect_addr,
    output logic                   mem_en,
    output logic [WIDTH_ADDR-1:0]  mem_addr,
    input  logic [WIDTH_INSTR-1:0] mem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH_INSTR-1:0] out_instr,
    output logic [WIDTH_ADDR-1:0]  out_addr,
    output logic                   busy,
    output logic                   done
);

    state_t                  state_q;
    logic [WIDTH_ADDR-1:0]   pc_q;
    logic [WIDTH_ADDR-1:0]   tag_q;
    logic                    inflight_q;
    logic                    done_q;

    buf_entry_t              push_entry;
    buf_entry_t              head;
    logic                    buf_empty;
    logic [1:0]              buf_count;
    logic [1:0]              credit_used;
    logic                    pop;
    logic                    push;
    logic                    flush;
    logic                    redirect_act;
    logic                    halt_acc;

    assign out_valid    = !buf_empty;
    assign pop          = out_valid && out_ready;
    assign redirect_act = (state_q == RUN) && redirect && !stop;
    assign halt_acc     = (state_q == RUN) && pop && (head.instr == HALT_OPCODE)
                          && !stop && !redirect;
    assign flush        = stop || redirect_act || halt_acc;

    // Counting this cycle's pop lets two entries sustain one instruction per cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        credit_used = buf_count + {1'b0, inflight_q} - {1'b0, pop};
        mem_en      = 1'b0;
        if ((state_q == RUN) && !flush && (credit_used < 2'd2)) begin
            mem_en = 1'b1;
        end
    end

    // A response landing in a flush cycle is dropped, never buffered.
    assign push       = inflight_q && (state_q == RUN) && !flush;
    assign push_entry = '{addr: tag_q, instr: mem_rdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= mem_en;
            done_q     <= halt_acc;
            if (mem_en) begin
                tag_q <= pc_q;
            end
            unique case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_q <= RUN;
                        pc_q    <= start_addr;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= IDLE;
                    end else if (redirect) begin
                        pc_q <= redirect_addr;
                    end else if (halt_acc) begin
                        state_q <= DRAIN;
                    end else if (mem_en) begin
                        pc_q <= pc_q + WIDTH_ADDR'(1);
                    end
                end
                DRAIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    fetch_buf #(
        .WIDTH($bits(buf_entry_t))
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (buf_empty),
        .count_o     (buf_count)
    );

    assign mem_addr  = pc_q;
    assign out_instr = head.instr;
    assign out_addr  = head.addr;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: cycle table for the start/backpressure
// stream, hand-written sequences for redirect, wrap, halt, stop and reset.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] start_addr = '0;
    logic       stop = 1'b0;
    logic       redirect = 1'b0;
    logic [7:0] redirect_addr = '0;
    logic       mem_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_instr;
    logic [7:0] out_addr;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int dc0;

    logic [7:0] ram [256];
    buf_entry_t exp_q [$];
    buf_entry_t sb_e;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= ram[mem_addr];
    end

    fetch_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .start_addr    (start_addr),
        .stop          (stop),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_addr      (out_addr),
        .busy          (busy),
        .done          (done)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_run(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] a;
            a = first + 8'(i);
            exp_q.push_back('{addr: a, instr: ram[a]});
        end
    endtask

    task automatic step(input logic st, input logic [7:0] sa, input logic rdy,
                        input logic sp, input logic rd, input logic [7:0] ra);
        @(posedge clk);
        #1;
        start         = st;
        start_addr    = sa;
        out_ready     = rdy;
        stop          = sp;
        redirect      = rd;
        redirect_addr = ra;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Scoreboard: every delivered handshake must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra delivered addr=%0h instr=%0h with nothing expected", out_addr, out_instr);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_addr", out_addr, sb_e.addr);
                check("sb_instr", out_instr, sb_e.instr);
            end
        end
        if (!rst && done) done_cnt++;
    end

    typedef struct {
        logic       start;
        logic       ready;
        logic       stop;
        logic       e_mem_en;
        logic [7:0] e_mem_addr;
        logic       e_valid;
        logic [7:0] e_addr;
        logic       e_busy;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i & 8'h7F);

        // start 0x10, ready high, 5-cycle backpressure, then stop
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 1'b1, 8'h10, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h13, 1'b1, 8'h11, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h14, 1'b1, 8'h12, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h15, 1'b1, 8'h13, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h15, 1'b1, 8'h13, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h15, 1'b1, 8'h13, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h15, 1'b1, 8'h13, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h15, 1'b1, 8'h13, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h15, 1'b1, 8'h13, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h16, 1'b1, 8'h14, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h17, 1'b1, 8'h15, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h18, 1'b1, 8'h16, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h18, 1'b0, 8'h00, 1'b0};

        // reset state
        @(negedge clk);
        check("rst_mem_en", 8'(mem_en), 8'd0);
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_out_instr", out_instr, 8'h00);
        check("rst_out_addr", out_addr, 8'h00);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // stream with backpressure
        expect_run(8'h10, 6);
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].start, 8'h10, vecs[i].ready, vecs[i].stop, 1'b0, 8'h00);
            check($sformatf("t1_mem_en[%0d]", i), 8'(mem_en), 8'(vecs[i].e_mem_en));
            check($sformatf("t1_mem_addr[%0d]", i), mem_addr, vecs[i].e_mem_addr);
            check($sformatf("t1_valid[%0d]", i), 8'(out_valid), 8'(vecs[i].e_valid));
            if (vecs[i].e_valid) check($sformatf("t1_out_addr[%0d]", i), out_addr, vecs[i].e_addr);
            check($sformatf("t1_busy[%0d]", i), 8'(busy), 8'(vecs[i].e_busy));
        end
        check("t1_all_delivered", 8'(exp_q.size()), 8'd0);
        check("t1_no_done", 8'(done_cnt), 8'd0);

        // redirect with 2 buffered (handshake in redirect cycle), then 1 buffered + 1 in flight
        expect_run(8'h20, 1);
        expect_run(8'h40, 1);
        expect_run(8'h60, 1);
        step(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rd_first_issue", mem_addr, 8'h20);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rd_full_no_issue", 8'(mem_en), 8'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rd_buffered_head", out_addr, 8'h20);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h40);
        check("rd1_mem_en_off", 8'(mem_en), 8'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("rd1_target_en", 8'(mem_en), 8'd1);
        check("rd1_target_addr", mem_addr, 8'h40);
        check("rd1_flushed", 8'(out_valid), 8'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("rd1_next_addr", out_addr, 8'h40);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h60);
        check("rd2_head_before", out_addr, 8'h41);
        check("rd2_mem_en_off", 8'(mem_en), 8'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("rd2_flushed", 8'(out_valid), 8'd0);
        check("rd2_target_addr", mem_addr, 8'h60);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("rd2_next_addr", out_addr, 8'h60);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        idle(1);
        check("rd_all_delivered", 8'(exp_q.size()), 8'd0);

        // wrap-around
        expect_run(8'hFE, 4);
        step(1'b1, 8'hFE, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("wrap_issue_fe", mem_addr, 8'hFE);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("wrap_issue_00", mem_addr, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        idle(1);
        check("wrap_all_delivered", 8'(exp_q.size()), 8'd0);

        // halt at 0x05; start while running is ignored
        ram[8'h05] = 8'hFF;
        dc0 = done_cnt;
        expect_run(8'h03, 3);
        step(1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("halt_start_ignored", mem_addr, 8'h05);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("halt_mem_en_off", 8'(mem_en), 8'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("halt_done_pulse", 8'(done), 8'd1);
        check("halt_drain_busy", 8'(busy), 8'd1);
        check("halt_drain_empty", 8'(out_valid), 8'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("halt_idle_busy", 8'(busy), 8'd0);
        check("halt_done_low", 8'(done), 8'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("halt_done_once", 8'(done_cnt - dc0), 8'd1);
        check("halt_all_delivered", 8'(exp_q.size()), 8'd0);
        ram[8'h05] = 8'h05;

        // stop and redirect together with a full buffer
        dc0 = done_cnt;
        step(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        check("sr_full_before", 8'(out_valid), 8'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h70);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("sr_idle", 8'(busy), 8'd0);
        check("sr_empty", 8'(out_valid), 8'd0);
        check("sr_no_fetch", 8'(mem_en), 8'd0);
        check("sr_pc_kept", mem_addr, 8'h32);
        idle(2);
        check("sr_no_done", 8'(done_cnt - dc0), 8'd0);

        // reset in the middle of a run
        expect_run(8'h50, 1);
        step(1'b1, 8'h50, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mrst_mem_en", 8'(mem_en), 8'd0);
        check("mrst_mem_addr", mem_addr, 8'h00);
        check("mrst_out_valid", 8'(out_valid), 8'd0);
        check("mrst_out_instr", out_instr, 8'h00);
        check("mrst_out_addr", out_addr, 8'h00);
        check("mrst_busy", 8'(busy), 8'd0);
        check("mrst_done", 8'(done), 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        check("mrst_stays_idle", 8'(busy), 8'd0);
        check("mrst_all_delivered", 8'(exp_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
